// File: rtl/if_fetch_unit.sv
// Instruction fetch: holds the PC, issues one-outstanding word reads and realigns RV32IC instructions into the IF/ID slot.
// Latency: the output slot is loaded in the imem_rvalid_i cycle, so instr_valid_o rises one cycle after rvalid.
// Backpressure: the output slot holds while id_ready_i=0; no new read is issued until the slot is free.
// Optional macro IF_RVC_EN builds the halfword buffer and compressed/spanning realignment.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    input  logic              id_ready_i,
    output logic              instr_valid_o,
    output logic [31:0]       instr_o,
    output logic [31:0]       pc_o,
    output logic              is_compressed_o
);

    // pc_q is the PC of the next instruction to emit; fetch_pc_q is the next word to read.
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        outst_q, outst_d;
    logic        drop_q, drop_d;

    // IF/ID output slot
    logic        slot_vld_q, slot_vld_d;
    logic [31:0] slot_instr_q, slot_instr_d;
    logic [31:0] slot_pc_q, slot_pc_d;

    logic        slot_free;
    logic        rsp_take;
    logic        buf_supply;
    logic        req;
    logic [31:0] redir_pc;
    logic [31:0] fetch_pc_next;
    logic        unused_bits;

`ifdef IF_RVC_EN
    // Buffered upper halfword; when valid its PC is always pc_q (pc_q[1]=1).
    logic [15:0] buf_q, buf_d;
    logic        buf_vld_q, buf_vld_d;
    logic        slot_comp_q, slot_comp_d;
    logic [15:0] rd_lo, rd_hi;

    assign rd_lo      = imem_rdata_i[15:0];
    assign rd_hi      = imem_rdata_i[31:16];
    assign buf_supply = buf_vld_q && (buf_q[1:0] != 2'b11);
    assign redir_pc   = {redirect_pc_i[31:1], 1'b0};
`else
    assign buf_supply = 1'b0;
    assign redir_pc   = {redirect_pc_i[31:2], 2'b00};
`endif

    assign unused_bits   = ^{redirect_pc_i[1:0], fetch_pc_q[1:0]};
    assign slot_free     = !slot_vld_q || id_ready_i;
    assign rsp_take      = imem_rvalid_i && outst_q && !drop_q;
    assign fetch_pc_next = {fetch_pc_q[31:2] + 30'd1, 2'b00};

    // A read is issued only when the buffer cannot supply the next instruction and the slot can take the result.
    assign req = rst_n && !outst_q && !redirect_i && !buf_supply && slot_free;

    assign imem_req_o    = req;
    assign imem_addr_o   = fetch_pc_q[ADDR_W+1:2];
    assign instr_valid_o = slot_vld_q;
    assign instr_o       = slot_instr_q;
    assign pc_o          = slot_pc_q;
`ifdef IF_RVC_EN
    assign is_compressed_o = slot_comp_q;
`else
    assign is_compressed_o = 1'b0;
`endif

    // Next-state: redirect first, then a memory response, then emission straight from the buffer.
    always_comb begin
        pc_d         = pc_q;
        fetch_pc_d   = fetch_pc_q;
        outst_d      = outst_q;
        drop_d       = drop_q;
        slot_vld_d   = slot_vld_q && !id_ready_i;
        slot_instr_d = slot_instr_q;
        slot_pc_d    = slot_pc_q;
`ifdef IF_RVC_EN
        slot_comp_d  = slot_comp_q;
        buf_d        = buf_q;
        buf_vld_d    = buf_vld_q;
`endif
        if (imem_rvalid_i && outst_q) begin
            outst_d = 1'b0;
            drop_d  = 1'b0;
        end
        if (req) begin
            outst_d = 1'b1;
        end

        if (redirect_i) begin
            pc_d       = redir_pc;
            fetch_pc_d = redir_pc;
            slot_vld_d = 1'b0;
            // A response still in flight belongs to the old path; one arriving now is simply ignored.
            drop_d     = outst_q && !imem_rvalid_i;
`ifdef IF_RVC_EN
            buf_vld_d  = 1'b0;
`endif
        end else if (rsp_take) begin
            fetch_pc_d = fetch_pc_next;
`ifdef IF_RVC_EN
            if (!pc_q[1]) begin
                if (rd_lo[1:0] != 2'b11) begin
                    slot_vld_d   = 1'b1;
                    slot_instr_d = {16'h0000, rd_lo};
                    slot_pc_d    = pc_q;
                    slot_comp_d  = 1'b1;
                    buf_d        = rd_hi;
                    buf_vld_d    = 1'b1;
                    pc_d         = pc_q + 32'd2;
                end else begin
                    slot_vld_d   = 1'b1;
                    slot_instr_d = imem_rdata_i;
                    slot_pc_d    = pc_q;
                    slot_comp_d  = 1'b0;
                    buf_vld_d    = 1'b0;
                    pc_d         = pc_q + 32'd4;
                end
            end else if (buf_vld_q) begin
                // Buffer holds the lower half of a 32-bit instruction spanning into this word.
                slot_vld_d   = 1'b1;
                slot_instr_d = {rd_lo, buf_q};
                slot_pc_d    = pc_q;
                slot_comp_d  = 1'b0;
                buf_d        = rd_hi;
                buf_vld_d    = 1'b1;
                pc_d         = pc_q + 32'd4;
            end else if (rd_hi[1:0] != 2'b11) begin
                // Redirect into an odd halfword: the upper half is a complete compressed instruction.
                slot_vld_d   = 1'b1;
                slot_instr_d = {16'h0000, rd_hi};
                slot_pc_d    = pc_q;
                slot_comp_d  = 1'b1;
                buf_vld_d    = 1'b0;
                pc_d         = pc_q + 32'd2;
            end else begin
                // Redirect into an odd halfword that starts a 32-bit instruction: park it and read on.
                buf_d     = rd_hi;
                buf_vld_d = 1'b1;
            end
`else
            slot_vld_d   = 1'b1;
            slot_instr_d = imem_rdata_i;
            slot_pc_d    = pc_q;
            pc_d         = pc_q + 32'd4;
`endif
        end
`ifdef IF_RVC_EN
        else if (buf_supply && slot_free) begin
            slot_vld_d   = 1'b1;
            slot_instr_d = {16'h0000, buf_q};
            slot_pc_d    = pc_q;
            slot_comp_d  = 1'b1;
            buf_vld_d    = 1'b0;
            pc_d         = pc_q + 32'd2;
        end
`endif
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            fetch_pc_q   <= RESET_PC;
            outst_q      <= 1'b0;
            drop_q       <= 1'b0;
            slot_vld_q   <= 1'b0;
            slot_instr_q <= 32'h0;
            slot_pc_q    <= 32'h0;
`ifdef IF_RVC_EN
            slot_comp_q  <= 1'b0;
            buf_q        <= 16'h0;
            buf_vld_q    <= 1'b0;
`endif
        end else begin
            pc_q         <= pc_d;
            fetch_pc_q   <= fetch_pc_d;
            outst_q      <= outst_d;
            drop_q       <= drop_d;
            slot_vld_q   <= slot_vld_d;
            slot_instr_q <= slot_instr_d;
            slot_pc_q    <= slot_pc_d;
`ifdef IF_RVC_EN
            slot_comp_q  <= slot_comp_d;
            buf_q        <= buf_d;
            buf_vld_q    <= buf_vld_d;
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a queued instruction-memory responder of programmable latency.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_o;
    logic [9:0]  imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_ready_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        is_compressed_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:127];
    int lat     = 1;
    int cyc     = 0;
    int req_cnt = 0;
    int a0_cnt  = 0;

    typedef struct {
        int          due;
        logic [31:0] dat;
    } rsp_t;
    rsp_t rq[$];

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(10)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .id_ready_i      (id_ready_i),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .is_compressed_o (is_compressed_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: requests are seen at negedge, data returns 'lat' negedges later.
    initial begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            imem_rvalid_i = 1'b0;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = rq[0].dat;
                rq.delete(0);
            end
            if (imem_req_o) begin
                rq.push_back('{cyc + lat, mem[imem_addr_o[6:0]]});
                req_cnt++;
                if (imem_addr_o == 10'd0) a0_cnt++;
            end
        end
    end

    task automatic hold_reset(input logic rdy);
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        id_ready_i    = rdy;
        lat           = 1;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013;
        repeat (8) @(posedge clk);
        #1;
        req_cnt = 0;
        a0_cnt  = 0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (instr_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        hold_reset(1'b1);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;
        @(negedge clk);
        #1;
        total++;
        if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: req=%b vld=%b, want 0 0", imem_req_o, instr_valid_o);
        end
        total++;
        if (instr_o !== 32'h0 || pc_o !== 32'h0 || is_compressed_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_dat: instr=%h pc=%h c=%b, want zeros", instr_o, pc_o, is_compressed_o);
        end
        release_reset();
        @(negedge clk);
        #1;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 10'd0) begin
            bad++;
            $display("FAIL first_req: req=%b addr=%0d, want 1 0", imem_req_o, imem_addr_o);
        end
        wait_valid(ok);
        total++;
        if (!ok || instr_o !== 32'h0050_0093 || pc_o !== 32'h0 || is_compressed_o !== 1'b0) begin
            bad++;
            $display("FAIL first_instr: ok=%b instr=%h pc=%h c=%b, want 00500093 0 0", ok, instr_o, pc_o, is_compressed_o);
        end
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 10'd1) begin
            bad++;
            $display("FAIL next_addr: req=%b addr=%0d, want 1 1", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_compressed();
        bit          ok;
        logic [31:0] ei [3];
        logic [31:0] ep [3];
        logic        ec [3];
        hold_reset(1'b1);
        mem[0] = 32'h4001_4501;
`ifdef IF_RVC_EN
        ei = '{32'h0000_4501, 32'h0000_4001, 32'h0000_0013};
        ep = '{32'h0, 32'h2, 32'h4};
        ec = '{1'b1, 1'b1, 1'b0};
`else
        ei = '{32'h4001_4501, 32'h0000_0013, 32'h0000_0013};
        ep = '{32'h0, 32'h4, 32'h8};
        ec = '{1'b0, 1'b0, 1'b0};
`endif
        release_reset();
        for (int k = 0; k < 3; k++) begin
            wait_valid(ok);
            total++;
            if (!ok || instr_o !== ei[k] || pc_o !== ep[k] || is_compressed_o !== ec[k]) begin
                bad++;
                $display("FAIL comp%0d: ok=%b instr=%h pc=%h c=%b, want %h %h %b", k, ok, instr_o, pc_o, is_compressed_o, ei[k], ep[k], ec[k]);
            end
        end
        total++;
        if (a0_cnt !== 1) begin
            bad++;
            $display("FAIL comp_word0_reqs: got %0d, want 1", a0_cnt);
        end
    endtask

    task automatic test_span();
        bit          ok;
        logic [31:0] ei [4];
        logic [31:0] ep [4];
        logic        ec [4];
        hold_reset(1'b1);
        mem[0] = 32'h00B3_4501;
        mem[1] = 32'h1234_0020;
`ifdef IF_RVC_EN
        ei = '{32'h0000_4501, 32'h0020_00B3, 32'h0000_1234, 32'h0000_0013};
        ep = '{32'h0, 32'h2, 32'h6, 32'h8};
        ec = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        ei = '{32'h00B3_4501, 32'h1234_0020, 32'h0000_0013, 32'h0000_0013};
        ep = '{32'h0, 32'h4, 32'h8, 32'hC};
        ec = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        release_reset();
        for (int k = 0; k < 4; k++) begin
            wait_valid(ok);
            total++;
            if (!ok || instr_o !== ei[k] || pc_o !== ep[k] || is_compressed_o !== ec[k]) begin
                bad++;
                $display("FAIL span%0d: ok=%b instr=%h pc=%h c=%b, want %h %h %b", k, ok, instr_o, pc_o, is_compressed_o, ei[k], ep[k], ec[k]);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        hold_reset(1'b0);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;
        release_reset();
        wait_valid(ok);
        total++;
        if (!ok || instr_o !== 32'h0050_0093 || pc_o !== 32'h0) begin
            bad++;
            $display("FAIL stall_first: ok=%b instr=%h pc=%h, want 00500093 0", ok, instr_o, pc_o);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (instr_valid_o !== 1'b1 || instr_o !== 32'h0050_0093 || pc_o !== 32'h0 || imem_req_o !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d: vld=%b instr=%h pc=%h req=%b, want 1 00500093 0 0", i, instr_valid_o, instr_o, pc_o, imem_req_o);
            end
        end
        total++;
        if (req_cnt !== 1) begin
            bad++;
            $display("FAIL stall_reqs: got %0d, want 1", req_cnt);
        end
        @(posedge clk);
        #1;
        id_ready_i = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b1 || imem_addr_o !== 10'd1) begin
            bad++;
            $display("FAIL stall_release: vld=%b req=%b addr=%0d, want 1 1 1", instr_valid_o, imem_req_o, imem_addr_o);
        end
        @(negedge clk);
        #1;
        total++;
        if (instr_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_consumed: vld=%b, want 0", instr_valid_o);
        end
        wait_valid(ok);
        total++;
        if (!ok || instr_o !== 32'h0010_0113 || pc_o !== 32'h4) begin
            bad++;
            $display("FAIL stall_next: ok=%b instr=%h pc=%h, want 00100113 4", ok, instr_o, pc_o);
        end
    endtask

    task automatic test_redirect();
        bit          ok;
        bit          found;
        bit          saw_vld;
        logic [31:0] ei [2];
        logic [31:0] ep [2];
        logic        ec [2];
        hold_reset(1'b1);
        mem[0]  = 32'h0050_0093;
        mem[64] = 32'h4581_0001;
`ifdef IF_RVC_EN
        ei = '{32'h0000_4581, 32'h0000_0013};
        ep = '{32'h102, 32'h104};
        ec = '{1'b1, 1'b0};
`else
        ei = '{32'h4581_0001, 32'h0000_0013};
        ep = '{32'h100, 32'h104};
        ec = '{1'b0, 1'b0};
`endif
        lat = 3;
        release_reset();
        @(negedge clk);
        #1;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 10'd0) begin
            bad++;
            $display("FAIL redir_req0: req=%b addr=%0d, want 1 0", imem_req_o, imem_addr_o);
        end
        @(posedge clk);
        #1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        @(posedge clk);
        #1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        @(negedge clk);
        #1;
        total++;
        if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
            bad++;
            $display("FAIL redir_flush: vld=%b req=%b, want 0 0", instr_valid_o, imem_req_o);
        end
        found   = 1'b0;
        saw_vld = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (instr_valid_o) saw_vld = 1'b1;
            if (imem_req_o) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found || saw_vld || imem_addr_o !== 10'h40) begin
            bad++;
            $display("FAIL redir_newreq: found=%b stale_vld=%b addr=%h, want 1 0 040", found, saw_vld, imem_addr_o);
        end
        for (int k = 0; k < 2; k++) begin
            wait_valid(ok);
            total++;
            if (!ok || instr_o !== ei[k] || pc_o !== ep[k] || is_compressed_o !== ec[k]) begin
                bad++;
                $display("FAIL redir%0d: ok=%b instr=%h pc=%h c=%b, want %h %h %b", k, ok, instr_o, pc_o, is_compressed_o, ei[k], ep[k], ec[k]);
            end
        end
    endtask

    task automatic test_reset_outstanding();
        bit ok;
        hold_reset(1'b1);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;
        lat = 4;
        release_reset();
        wait_valid(ok);
        total++;
        if (!ok || instr_o !== 32'h0050_0093 || req_cnt !== 2) begin
            bad++;
            $display("FAIL rst_pre: ok=%b instr=%h reqs=%0d, want 00500093 2", ok, instr_o, req_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 32'h0 || is_compressed_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: req=%b vld=%b instr=%h pc=%h c=%b, want all 0", imem_req_o, instr_valid_o, instr_o, pc_o, is_compressed_o);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 10'd0) begin
            bad++;
            $display("FAIL rst_restart: req=%b addr=%0d, want 1 0", imem_req_o, imem_addr_o);
        end
        wait_valid(ok);
        total++;
        if (!ok || instr_o !== 32'h0050_0093 || pc_o !== 32'h0) begin
            bad++;
            $display("FAIL rst_late_rsp: ok=%b instr=%h pc=%h, want 00500093 0", ok, instr_o, pc_o);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        id_ready_i    = 1'b1;
        test_reset();
        test_compressed();
        test_span();
        test_stall();
        test_redirect();
        test_reset_outstanding();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch initiator for the RV32IC pipeline; the read-side counterpart of the instruction memory.
- Holds the PC, issues word reads to instruction memory and accepts responses through a one-outstanding request/valid handshake.
- Realigns 16-bit compressed and 32-bit instructions, including 32-bit instructions that span a word boundary.
- Drives the IF/ID pipeline register with instruction, PC and a compressed flag, under backpressure and branch redirect.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; bit 0 must be 0.
- ADDR_W, 10: width of the word address into instruction memory.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- imem_req_o  out  1  one-cycle read request pulse
- imem_addr_o  out  ADDR_W  word address, equal to fetch_pc[ADDR_W+1:2], valid while imem_req_o=1
- imem_rvalid_i  in  1  read data valid, at least 1 cycle after the request
- imem_rdata_i  in  32  read word, little-endian halfwords
- redirect_i  in  1  branch/jump redirect
- redirect_pc_i  in  32  target PC, halfword aligned
- id_ready_i  in  1  IF/ID register can accept
- instr_valid_o  out  1  instr_o and pc_o hold a valid instruction
- instr_o  out  32  instruction; compressed instructions are zero-extended from [15:0]
- pc_o  out  32  PC of instr_o
- is_compressed_o  out  1  instr_o is a 16-bit instruction

Behaviour:
- Reset (rst_n=0 at clk edge):
  - pc and fetch_pc are set to RESET_PC.
  - Halfword buffer is emptied; outstanding and drop flags are cleared.
  - All outputs are 0: imem_req_o, instr_valid_o, instr_o, pc_o, is_compressed_o.
  - An in-flight response arriving after reset is ignored because the outstanding flag is clear.
- Request issue: imem_req_o=1 for one cycle only when all of the following hold:
  - no request is outstanding;
  - no redirect this cycle;
  - the buffer cannot by itself supply the next instruction;
  - the output slot is empty, or is being consumed (instr_valid_o & id_ready_i).
- Request rules:
  - At most one request is outstanding.
  - The first request after reset is issued in the cycle after rst_n rises.
- Output handshake:
  - An instruction transfers when instr_valid_o & id_ready_i.
  - While instr_valid_o=1 and id_ready_i=0, instr_o, pc_o and is_compressed_o are held stable.
- Realignment, with lo = imem_rdata_i[15:0] and hi = imem_rdata_i[31:16]:
  - pc[1]=0, lo[1:0]!=2'b11: emit lo as compressed. Buffer hi with pc+2. pc += 2.
  - pc[1]=0, lo[1:0]=2'b11: emit the full word. pc += 4. Buffer stays empty.
  - pc[1]=1, buffered half has [1:0]!=2'b11: emit it as compressed from the buffer, with no memory access. pc += 2.
  - pc[1]=1, buffered half has [1:0]=2'b11: fetch the next word and emit {lo, buffer}. Buffer hi. pc += 4.
  - pc[1]=1 with the buffer empty (after a redirect): fetch the word and use hi as the buffered half, then apply the two pc[1]=1 rules above.
- Latency: the response is registered into the output slot in the cycle imem_rvalid_i=1, so instr_valid_o rises one cycle after imem_rvalid_i.
- Redirect (highest priority):
  - In the redirect cycle the output slot and buffer are flushed; instr_valid_o=0 on the next cycle.
  - pc and fetch_pc are loaded from redirect_pc_i.
  - If a request is outstanding, the drop flag is set and the next rvalid response is discarded; the new request is issued after that discard.
  - redirect_pc_i[0] is ignored (treated as 0).
  - A redirect that coincides with rvalid discards that response.
- Arithmetic: pc wraps modulo 2^32. The memory address is truncated to ADDR_W bits, so it wraps at 2^(ADDR_W+2) bytes.
- No response timeout: the unit waits indefinitely for imem_rvalid_i.

Optional Feature:
- Macro IF_RVC_EN.
  - Defined: full compressed realignment as described above.
  - Undefined:
    - Halfword buffer and spanning logic are not built.
    - Every word is emitted as a 32-bit instruction; pc += 4.
    - is_compressed_o is tied to 0.
    - redirect_pc_i[1:0] are ignored (treated as 0).

Test Plan:
- Reset with RESET_PC=0x0, memory word0=0x00500093, id_ready_i=1 -> imem_addr_o=0 and req on the first cycle after reset. Then instr_o=0x00500093, pc_o=0x0, is_compressed_o=0, next addr=1.
- Word0=0x40014501 (two compressed halves) -> instr_o=0x00004501 at pc 0x0, then 0x00004001 at pc 0x2, both with is_compressed_o=1. Only one memory request is issued for word0.
- Word0=0x00B3_4501, word1=0x1234_0020 -> compressed 0x4501 at pc 0x0, then spanning 32-bit instruction 0x002000B3 at pc 0x2. Buffer then holds 0x1234 with pc 0x6.
- id_ready_i=0 for 5 cycles with a valid output -> instr_o and pc_o are unchanged and no new request is issued; the transfer completes on the first cycle id_ready_i=1.
- redirect_i=1, redirect_pc_i=0x102 while a request is outstanding -> the stale response is dropped and instr_valid_o=0. Next request addr=0x40, and hi of that word is treated as the pc 0x102 halfword.
- Reset asserted while a request is outstanding -> all outputs are 0 and the late rvalid is ignored. Fetch restarts at RESET_PC.
